clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable integer clock divider with a glitch-free divisor-update handshake and a clean enable/park mechanism. It generates a divided clock `clk_out` with near-50% duty cycle and a one-cycle `tick` strobe at each period start. It generalises the fixed divide-by-4 block and serves as the common clock/strobe source for peripheral timing (baud, SPI SCK, sampling enables).

## Interface
- `W`, 8: width of the divisor and of the internal counter.
- `DEFAULT_DIV`, 4: active divisor after reset; values below 2 are clamped to 2.

- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run request; sampled only at boundary edges
- `div_in`  in  W  requested divisor N
- `div_valid`  in  1  divisor request valid
- `div_ready`  out  1  divider can accept a divisor
- `clk_out`  out  1  divided clock (registered)
- `tick`  out  1  one-`clk` pulse coincident with each `clk_out` rise
- `active`  out  1  divider is generating periods (not parked)
- `cur_div`  out  W  divisor currently in use

## Operation
- **Reset values:** `clk_out`=0, `tick`=0, `active`=0, `div_ready`=1, `cur_div`=clamp(`DEFAULT_DIV`), pending slot empty, counter 0.
- **Period:** N `clk` cycles. `clk_out` is high for H = floor(N/2) cycles, then low for N−H cycles.
- **Boundary edge:** an edge that ends the last cycle of a period (count = N−1), or any edge while parked.
- **At a boundary edge:**
  - Pending divisor present: it is loaded into `cur_div` first.
  - `en`=1: a new period starts; `clk_out`→1, `tick`=1 for this cycle, `active`=1.
  - `en`=0: the block parks; `clk_out`=0, `active`=0, counter 0.
- **Enable behaviour:**
  - `en` changes mid-period are ignored; no runt pulses are produced.
  - `en` asserted while parked starts a period on the next edge.
- **Divisor handshake:**
  - A transfer occurs when `div_valid` & `div_ready` are both high at an edge. `div_in` is stored in the pending slot and `div_ready` drops on that edge.
  - `div_ready` reasserts on the boundary edge that applies the pending value.
  - `div_valid` while `div_ready`=0 is ignored; the requester holds its value.
- **Clamping:** `div_in` < 2 (0 or 1) is clamped to 2 on acceptance.
- **Counter width:** the counter is W bits. N = 2^W−1 is legal; there is no overflow because the counter is compared to N−1.
- **Reset mid-operation:** all state returns to reset values on that edge and the pending divisor is discarded.
- **Simultaneous events:** a transfer on a boundary edge while parked is applied on the following edge; it is never dropped.

## Timing
- Reset is synchronous; the first enabled period starts on the first edge with `rst`=0 and `en`=1.
- `clk_out` and `tick` are register outputs with no combinational path from inputs.
- Divisor-change latency: from the accept edge to the end of the current period (at most N_old cycles). While parked, the change takes effect on the next edge.
- Park latency: at most N−1 cycles after `en` falls.
- Example, N=4, `en`=1 from the first edge (E1): `clk_out` is high after E1 and E2, low after E3 and E4, high after E5; `tick` pulses after E1 and E5.

## Configuration
- **`CLK_DIV_ODD_DUTY50_EN` defined:**
  - For odd N, a negedge-`clk` flop delays the posedge `clk_out` term by half a cycle. The output is the OR of the posedge term and the delayed term, giving exactly N/2 cycles high (50% duty).
  - Even N and `tick` are unaffected.
  - Parking extends the final high phase by at most half a cycle, still glitch-free.
- **Not defined:** there are no negedge flops; odd N gives a high phase of floor(N/2) cycles.

## Test plan
- Reset, then `en`=1 with the default divisor → `clk_out` period 4 with pattern 1100, a `tick` every 4 cycles, and `cur_div`=4.
- `div_in`=5 accepted mid-period → `div_ready`=0 until the boundary, then the pattern becomes 11000. With the macro defined, the high phase measures 2.5 `clk` periods.
- `div_in`=0 → `cur_div`=2 after the boundary and `clk_out` toggles every cycle.
- `en` dropped 1 cycle into an N=6 period → the period completes (3 high, 3 low), then `active`=0 and `clk_out` stays 0. Reasserting `en` → `tick` on the next edge.
- `div_valid` held while `div_ready`=0 with a second value → only the first value is applied; the second is accepted after `div_ready` reasserts.
- `rst` pulsed while `clk_out`=1 with a pending divisor → all outputs return to reset values on that edge, the pending value is lost, and `cur_div`=`DEFAULT_DIV`.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Purpose  : Programmable integer clock divider. Produces a divided clock
//             (clk_out) with near-50% duty cycle and a one-cycle tick strobe
//             at the start of each period. The divisor is updated through a
//             valid/ready handshake and only takes effect on a period
//             boundary, so no runt or stretched pulses appear on clk_out.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    W            width of the divisor and of the period counter
//    DEFAULT_DIV  divisor in use after reset (values below 2 become 2)
//  Ports
//    clk        in   system clock
//    rst        in   synchronous, active-high reset
//    en         in   run request, sampled only on boundary edges
//    div_in     in   requested divisor N
//    div_valid  in   divisor request valid
//    div_ready  out  divider can accept a divisor (pending slot empty)
//    clk_out    out  divided clock
//    tick       out  one-clk strobe coincident with each clk_out rise
//    active     out  divider is generating periods (not parked)
//    cur_div    out  divisor currently in use
//  Optional feature
//    CLK_DIV_ODD_DUTY50_EN : when defined, a negedge flop stretches the high
//    phase of odd divisors by half a clk cycle for an exact 50% duty cycle.
//    When undefined the design contains no negedge flops.
// ============================================================================
module clk_div_prog #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  input  logic         div_valid,
  output logic         div_ready,
  output logic         clk_out,
  output logic         tick,
  output logic         active,
  output logic [W-1:0] cur_div
);

  localparam logic [W-1:0] c_min_div     = W'(2);
  localparam logic [W-1:0] c_default_div = (DEFAULT_DIV < 2) ? c_min_div : W'(DEFAULT_DIV);

  logic [W-1:0] r_cnt;
  logic [W-1:0] r_cur_div;
  logic [W-1:0] r_pend_div;
  logic         r_pend_valid;
  logic         r_clk_out;
  logic         r_tick;
  logic         r_active;

  logic         w_boundary;
  logic         w_accept;
  logic [W-1:0] w_div_clamped;
  logic [W-1:0] w_cnt_inc;
  logic [W-1:0] w_high_len;

  // The counter only ever reaches N-1, so N = 2^W-1 never wraps it.
  assign w_boundary    = ~r_active | (r_cnt == (r_cur_div - W'(1)));
  assign w_accept      = div_valid & ~r_pend_valid;
  assign w_div_clamped = (div_in < c_min_div) ? c_min_div : div_in;
  assign w_cnt_inc     = r_cnt + W'(1);
  assign w_high_len    = r_cur_div >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_cur_div    <= c_default_div;
      r_pend_div   <= '0;
      r_pend_valid <= 1'b0;
      r_clk_out    <= 1'b0;
      r_tick       <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      if (w_boundary) begin
        // Apply any pending divisor before deciding on the next period. A
        // transfer landing on this same edge goes to the slot and waits for
        // the following boundary (ready was high, so the slot was empty).
        if (r_pend_valid) begin
          r_cur_div    <= r_pend_div;
          r_pend_valid <= 1'b0;
        end else if (w_accept) begin
          r_pend_div   <= w_div_clamped;
          r_pend_valid <= 1'b1;
        end
        r_cnt <= '0;
        if (en) begin
          r_active  <= 1'b1;
          r_clk_out <= 1'b1;   // high phase is floor(N/2) >= 1 cycle
          r_tick    <= 1'b1;
        end else begin
          r_active  <= 1'b0;
          r_clk_out <= 1'b0;
          r_tick    <= 1'b0;
        end
      end else begin
        if (w_accept) begin
          r_pend_div   <= w_div_clamped;
          r_pend_valid <= 1'b1;
        end
        r_cnt     <= w_cnt_inc;
        r_tick    <= 1'b0;
        // Stay high while the next count is still inside the high phase.
        r_clk_out <= (w_cnt_inc < w_high_len);
      end
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  // Half-cycle delayed copy of the high phase for odd divisors. The OR with
  // the posedge term never dips: the delayed term rises while the posedge
  // term is already high and falls half a cycle after it. Gating with
  // r_active clears the stretch immediately on reset; at a park the last
  // phase of a period is low, so the gate never truncates a pulse.
  logic r_half;

  always_ff @(negedge clk) begin
    if (rst) begin
      r_half <= 1'b0;
    end else begin
      r_half <= r_clk_out & r_cur_div[0];
    end
  end

  assign clk_out = r_clk_out | (r_half & r_active);
`else
  assign clk_out = r_clk_out;
`endif

  assign tick      = r_tick;
  assign active    = r_active;
  assign cur_div   = r_cur_div;
  assign div_ready = ~r_pend_valid;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clk_div_prog
//  Purpose  : Directed self-checking bench for clk_div_prog (W=8,
//             DEFAULT_DIV=4). Expected waveforms are hand-written strings,
//             one character per clk edge ('1' high, '0' low).
//  Revision : 1.0  initial release
// ============================================================================
module tb_clk_div_prog;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic         clk_out;
  logic         tick;
  logic         active;
  logic [W-1:0] cur_div;

  int tests = 0;
  int fails = 0;

  clk_div_prog #(
    .W           (W),
    .DEFAULT_DIV (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .active    (active),
    .cur_div   (cur_div)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One edge per character: cpat gives clk_out, tpat gives tick after it.
  task automatic expect_seq(input string tag, input string cpat, input string tpat);
    for (int i = 0; i < cpat.len(); i++) begin
      step();
      check($sformatf("%s clk_out[%0d]", tag, i), {31'd0, clk_out}, {31'd0, cpat[i] == "1"});
      check($sformatf("%s tick[%0d]", tag, i), {31'd0, tick}, {31'd0, tpat[i] == "1"});
    end
  endtask

  initial begin
    rst       = 1'b1;
    en        = 1'b0;
    div_in    = '0;
    div_valid = 1'b0;
    step();
    step();

    // Reset state
    check("rst clk_out",   {31'd0, clk_out},   0);
    check("rst tick",      {31'd0, tick},      0);
    check("rst active",    {31'd0, active},    0);
    check("rst div_ready", {31'd0, div_ready}, 1);
    check("rst cur_div",   {24'd0, cur_div},   4);

    // Default divisor 4: pattern 1100, tick every 4 edges
    rst = 1'b0;
    en  = 1'b1;
    expect_seq("div4", "110011001", "100010001");
    check("div4 active",  {31'd0, active},  1);
    check("div4 cur_div", {24'd0, cur_div}, 4);

    // Divisor 5 accepted one edge into a period
    div_in    = 8'd5;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("acc5 clk_out",   {31'd0, clk_out},   1);
    check("acc5 div_ready", {31'd0, div_ready}, 0);
    check("acc5 cur_div",   {24'd0, cur_div},   4);
    expect_seq("bnd5", "001", "001");
    check("bnd5 div_ready", {31'd0, div_ready}, 1);
    check("bnd5 cur_div",   {24'd0, cur_div},   5);
    expect_seq("div5", "10001", "00001");

    // Divisor 0 clamps to 2
    div_in    = 8'd0;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("acc0 div_ready", {31'd0, div_ready}, 0);
    expect_seq("div2", "00010101", "00010101");
    check("div2 cur_div",   {24'd0, cur_div},   2);
    check("div2 div_ready", {31'd0, div_ready}, 1);

    // Load 6, then drop en one cycle into the period
    div_in    = 8'd6;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("acc6 clk_out", {31'd0, clk_out}, 0);
    expect_seq("bnd6", "1", "1");
    check("bnd6 cur_div", {24'd0, cur_div}, 6);
    en = 1'b0;
    expect_seq("park6", "11000", "00000");
    check("park6 active pre", {31'd0, active}, 1);
    expect_seq("park6 end", "000", "000");
    check("park6 active", {31'd0, active}, 0);
    en = 1'b1;
    expect_seq("unpark", "1", "1");
    check("unpark active", {31'd0, active}, 1);

    // Held div_valid while not ready: second value waits for ready
    div_in    = 8'd3;
    div_valid = 1'b1;
    step();
    div_in = 8'd9;
    check("acc3 div_ready", {31'd0, div_ready}, 0);
    expect_seq("hold6", "1000", "0000");
    check("hold6 cur_div",   {24'd0, cur_div},   6);
    check("hold6 div_ready", {31'd0, div_ready}, 0);
    expect_seq("bnd3", "1", "1");
    check("bnd3 cur_div",   {24'd0, cur_div},   3);
    check("bnd3 div_ready", {31'd0, div_ready}, 1);
    step();   // 9 accepted on this edge
    div_valid = 1'b0;
    check("acc9 div_ready", {31'd0, div_ready}, 0);
    check("acc9 cur_div",   {24'd0, cur_div},   3);
    check("acc9 clk_out",   {31'd0, clk_out},   0);
    expect_seq("bnd9", "01", "01");
    check("bnd9 cur_div", {24'd0, cur_div}, 9);

    // Reset while clk_out high with a divisor pending
    div_in    = 8'd12;
    div_valid = 1'b1;
    step();
    div_valid = 1'b0;
    check("acc12 clk_out",   {31'd0, clk_out},   1);
    check("acc12 div_ready", {31'd0, div_ready}, 0);
    rst = 1'b1;
    step();
    check("mrst clk_out",   {31'd0, clk_out},   0);
    check("mrst tick",      {31'd0, tick},      0);
    check("mrst active",    {31'd0, active},    0);
    check("mrst div_ready", {31'd0, div_ready}, 1);
    check("mrst cur_div",   {24'd0, cur_div},   4);
    rst = 1'b0;
    expect_seq("post rst", "11001", "10001");
    check("post rst cur_div", {24'd0, cur_div}, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
